// File: rtl/fpu_ss_scoreboard_mp.sv
// Multi-port register hazard scoreboard and instruction-ID tracker for the FPU subsystem.
// Tracks pending writes per FP register, per-ID commit/execution state and writeback bypass.
module fpu_ss_scoreboard_mp #(
  parameter int NUM_REGS   = 32,
  parameter int ID_WIDTH   = 4,
  parameter int NUM_RS     = 3,
  parameter int NUM_WB     = 2,
  parameter int CNT_WIDTH  = 2,
  parameter int ALLOW_WAW  = 0,
  parameter int FORWARDING = 1,
  localparam int REG_AW    = $clog2(NUM_REGS)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       commit_valid_i,
  input  logic [ID_WIDTH-1:0]        commit_id_i,
  input  logic                       commit_kill_i,
  input  logic                       disp_valid_i,
  output logic                       disp_ready_o,
  input  logic [ID_WIDTH-1:0]        disp_id_i,
  input  logic [REG_AW-1:0]          disp_rd_i,
  input  logic                       disp_rd_we_i,
  input  logic [NUM_RS*REG_AW-1:0]   disp_rs_i,
  input  logic [NUM_RS-1:0]          disp_rs_use_i,
  input  logic [NUM_WB-1:0]          wb_valid_i,
  input  logic [NUM_WB*ID_WIDTH-1:0] wb_id_i,
  input  logic [NUM_WB*REG_AW-1:0]   wb_rd_i,
  input  logic [NUM_WB-1:0]          wb_we_i,
  output logic [NUM_RS*NUM_WB-1:0]   fwd_o,
  output logic                       dep_rs_o,
  output logic                       dep_rd_o,
  output logic [NUM_REGS-1:0]        pending_o,
  output logic                       busy_o,
  output logic                       err_o
);

  typedef enum logic [1:0] {
    ID_IDLE      = 2'd0,
    ID_COMMITTED = 2'd1,
    ID_INFLIGHT  = 2'd2
  } id_state_e;

  localparam int NUM_IDS = 2**ID_WIDTH;
  localparam int DW      = $clog2(NUM_WB + 1);
  localparam int SW      = CNT_WIDTH + DW + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];
  id_state_e            id_st_q [NUM_IDS];
  id_state_e            id_st_d [NUM_IDS];
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic [NUM_REGS-1:0]  pending_q, pending_d;

  logic [DW-1:0]        wb_hits [NUM_REGS];
  logic                 dep_rs, dep_rd, id_ready, dispatch;

  // Number of writeback ports retiring a write to each register this cycle
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      wb_hits[r] = '0;
      for (int j = 0; j < NUM_WB; j++) begin
        if (wb_valid_i[j] && wb_we_i[j] && wb_rd_i[j*REG_AW +: REG_AW] == REG_AW'(r))
          wb_hits[r] = wb_hits[r] + DW'(1);
      end
    end
  end

  always_comb begin
    logic [REG_AW-1:0] rs;
    logic              hit;
    logic              blocked;
    logic              commit_same;
    dep_rs      = 1'b0;
    fwd_o       = '0;
    rs          = '0;
    hit         = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      rs  = disp_rs_i[i*REG_AW +: REG_AW];
      hit = 1'b0;
      // A single outstanding write that retires this cycle is satisfied by the bypass
      if (disp_rs_use_i[i] && disp_valid_i && cnt_q[rs] != '0 &&
          !(FORWARDING != 0 && cnt_q[rs] == CNT_WIDTH'(1) && wb_hits[rs] != '0))
        dep_rs = 1'b1;
      if (FORWARDING != 0 && disp_rs_use_i[i]) begin
        for (int j = 0; j < NUM_WB; j++) begin
          if (!hit && wb_valid_i[j] && wb_we_i[j] && wb_rd_i[j*REG_AW +: REG_AW] == rs) begin
            fwd_o[i*NUM_WB + j] = 1'b1;
            hit = 1'b1;
          end
        end
      end
    end

    if (ALLOW_WAW != 0)
      blocked = (cnt_q[disp_rd_i] == CNT_MAX) && (wb_hits[disp_rd_i] == '0);
    else
      blocked = (cnt_q[disp_rd_i] != '0) &&
                ((cnt_q[disp_rd_i] > CNT_WIDTH'(1)) || (wb_hits[disp_rd_i] == '0));
    dep_rd = disp_valid_i && disp_rd_we_i && blocked;

    // A kill arriving for the head ID revokes its readiness in the same cycle
    commit_same = commit_valid_i && (commit_id_i == disp_id_i);
    id_ready    = ((id_st_q[disp_id_i] == ID_COMMITTED) && !(commit_same && commit_kill_i)) ||
                  (commit_same && !commit_kill_i);
  end

  assign dispatch     = disp_valid_i && id_ready && !dep_rs && !dep_rd;
  assign disp_ready_o = dispatch;
  assign dep_rs_o     = dep_rs;
  assign dep_rd_o     = dep_rd;

  always_comb begin
    logic [SW-1:0] sum;
    logic [SW-1:0] dec;
    logic          inc;
    err_d     = err_q;
    busy_d    = 1'b0;
    pending_d = '0;
    sum       = '0;
    dec       = '0;
    inc       = 1'b0;

    // ID tracking: commit/kill, then dispatch, then writeback retire
    for (int k = 0; k < NUM_IDS; k++) begin
      id_st_d[k] = id_st_q[k];
      if (commit_valid_i && commit_id_i == ID_WIDTH'(k)) begin
        case (id_st_q[k])
          ID_IDLE:      if (!commit_kill_i) id_st_d[k] = ID_COMMITTED;
          ID_COMMITTED: if (commit_kill_i) id_st_d[k] = ID_IDLE;
                        else err_d = 1'b1;
          default:      err_d = 1'b1;
        endcase
      end
      if (dispatch && disp_id_i == ID_WIDTH'(k))
        id_st_d[k] = ID_INFLIGHT;
      for (int j = 0; j < NUM_WB; j++) begin
        if (wb_valid_i[j] && wb_id_i[j*ID_WIDTH +: ID_WIDTH] == ID_WIDTH'(k)) begin
          if (id_st_q[k] == ID_INFLIGHT) id_st_d[k] = ID_IDLE;
          else                           err_d = 1'b1;
        end
      end
      if (id_st_d[k] == ID_INFLIGHT) busy_d = 1'b1;
    end

    for (int r = 0; r < NUM_REGS; r++) begin
      inc = dispatch && disp_rd_we_i && (disp_rd_i == REG_AW'(r));
      sum = SW'(cnt_q[r]) + SW'(inc);
      dec = SW'(wb_hits[r]);
      if (dec > sum) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = CNT_WIDTH'(sum - dec);
      end
      pending_d[r] = (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      for (int k = 0; k < NUM_IDS; k++) id_st_q[k] <= ID_IDLE;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      for (int k = 0; k < NUM_IDS; k++) id_st_q[k] <= id_st_d[k];
      err_q     <= err_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_fpu_ss_scoreboard_mp.sv
// Scoreboard bench: two scoreboard configurations (no-WAW with bypass, WAW without bypass)
// driven by the same stimulus and checked every cycle against an integer reference model.
module tb_fpu_ss_scoreboard_mp;
  localparam int NR = 32, NI = 16;
  localparam int IDLE = 0, COMM = 1, INFL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_valid, c_kill, d_valid, d_rdwe;
  logic [3:0]  c_id, d_id;
  logic [4:0]  d_rd;
  logic [14:0] d_rs;
  logic [2:0]  d_use;
  logic [1:0]  w_valid, w_we;
  logic [7:0]  w_id;
  logic [9:0]  w_rd;

  logic        rdy_w [2];
  logic        deprs_w [2];
  logic        deprd_w [2];
  logic        busy_w [2];
  logic        err_w [2];
  logic [5:0]  fwd_w [2];
  logic [31:0] pend_w [2];

  always #5 clk = ~clk;

  fpu_ss_scoreboard_mp #(.ALLOW_WAW(0), .FORWARDING(1)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .commit_valid_i(c_valid), .commit_id_i(c_id), .commit_kill_i(c_kill),
    .disp_valid_i(d_valid), .disp_ready_o(rdy_w[0]), .disp_id_i(d_id),
    .disp_rd_i(d_rd), .disp_rd_we_i(d_rdwe), .disp_rs_i(d_rs), .disp_rs_use_i(d_use),
    .wb_valid_i(w_valid), .wb_id_i(w_id), .wb_rd_i(w_rd), .wb_we_i(w_we),
    .fwd_o(fwd_w[0]), .dep_rs_o(deprs_w[0]), .dep_rd_o(deprd_w[0]),
    .pending_o(pend_w[0]), .busy_o(busy_w[0]), .err_o(err_w[0]));

  fpu_ss_scoreboard_mp #(.ALLOW_WAW(1), .FORWARDING(0)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .commit_valid_i(c_valid), .commit_id_i(c_id), .commit_kill_i(c_kill),
    .disp_valid_i(d_valid), .disp_ready_o(rdy_w[1]), .disp_id_i(d_id),
    .disp_rd_i(d_rd), .disp_rd_we_i(d_rdwe), .disp_rs_i(d_rs), .disp_rs_use_i(d_use),
    .wb_valid_i(w_valid), .wb_id_i(w_id), .wb_rd_i(w_rd), .wb_we_i(w_we),
    .fwd_o(fwd_w[1]), .dep_rs_o(deprs_w[1]), .dep_rd_o(deprd_w[1]),
    .pending_o(pend_w[1]), .busy_o(busy_w[1]), .err_o(err_w[1]));

  typedef struct packed {
    logic [1:0]  rdy, deprs, deprd, busy, err;
    logic [11:0] fwd;
    logic [63:0] pend;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nfail = 0;

  // Reference state: instance 0 = no WAW, bypass on; instance 1 = WAW, bypass off
  int   m_cnt [2][NR];
  int   m_st  [2][NI];
  int   m_rd  [2][NI];
  bit   m_we  [2][NI];
  bit   m_err [2];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int wbn(int r);
    int n = 0;
    for (int j = 0; j < 2; j++)
      if (w_valid[j] && w_we[j] && int'(w_rd[j*5 +: 5]) == r) n++;
    return n;
  endfunction

  task automatic model_comb(input int p, output bit rdy, output bit deprs,
                            output bit deprd, output bit [5:0] fwd);
    bit waw = (p == 1);
    bit byp = (p == 0);
    bit idr;
    int c, rs;
    deprs = 0;
    fwd   = '0;
    for (int i = 0; i < 3; i++) begin
      rs = int'(d_rs[i*5 +: 5]);
      c  = m_cnt[p][rs];
      if (d_use[i] && d_valid && c > 0 && !(byp && c == 1 && wbn(rs) > 0)) deprs = 1;
      if (byp && d_use[i]) begin
        for (int j = 0; j < 2; j++) begin
          if (w_valid[j] && w_we[j] && int'(w_rd[j*5 +: 5]) == rs) begin
            fwd[i*2 + j] = 1'b1;
            break;
          end
        end
      end
    end
    c = m_cnt[p][int'(d_rd)];
    if (waw) deprd = d_valid && d_rdwe && c == 3 && wbn(int'(d_rd)) == 0;
    else     deprd = d_valid && d_rdwe && c > 0 && (c > 1 || wbn(int'(d_rd)) == 0);
    idr = (m_st[p][int'(d_id)] == COMM && !(c_valid && c_kill && c_id == d_id)) ||
          (c_valid && !c_kill && c_id == d_id);
    rdy = d_valid && idr && !deprs && !deprd;
  endtask

  task automatic model_update(input int p, input bit disp);
    int nst [NI];
    int k, n;
    if (rst) begin
      for (int r = 0; r < NR; r++) m_cnt[p][r] = 0;
      for (int i = 0; i < NI; i++) m_st[p][i] = IDLE;
      m_err[p] = 0;
      return;
    end
    for (int i = 0; i < NI; i++) nst[i] = m_st[p][i];
    if (c_valid) begin
      k = int'(c_id);
      if (m_st[p][k] == IDLE) begin
        if (!c_kill) nst[k] = COMM;
      end else if (m_st[p][k] == COMM && c_kill) nst[k] = IDLE;
      else m_err[p] = 1;
    end
    if (disp) begin
      nst[int'(d_id)]    = INFL;
      m_rd[p][int'(d_id)] = int'(d_rd);
      m_we[p][int'(d_id)] = d_rdwe;
    end
    for (int j = 0; j < 2; j++) begin
      if (w_valid[j]) begin
        k = int'(w_id[j*4 +: 4]);
        if (m_st[p][k] == INFL) nst[k] = IDLE;
        else m_err[p] = 1;
      end
    end
    for (int r = 0; r < NR; r++) begin
      n = m_cnt[p][r] + ((disp && d_rdwe && int'(d_rd) == r) ? 1 : 0) - wbn(r);
      if (n < 0) begin
        n = 0;
        m_err[p] = 1;
      end
      m_cnt[p][r] = n;
    end
    for (int i = 0; i < NI; i++) m_st[p][i] = nst[i];
  endtask

  // Predict this cycle's outputs, queue them, then advance the model past the edge
  task automatic go();
    exp_t e;
    bit r, ds, dd;
    bit [5:0] f;
    e = '0;
    for (int p = 0; p < 2; p++) begin
      model_comb(p, r, ds, dd, f);
      e.rdy[p] = r; e.deprs[p] = ds; e.deprd[p] = dd;
      e.fwd[p*6 +: 6] = f;
      e.err[p] = m_err[p];
      for (int i = 0; i < NI; i++) if (m_st[p][i] == INFL) e.busy[p] = 1'b1;
      for (int x = 0; x < NR; x++) e.pend[p*32 + x] = (m_cnt[p][x] != 0);
    end
    q.push_back(e);
    for (int p = 0; p < 2; p++) model_update(p, e.rdy[p]);
    #2;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; c_valid = 0; c_id = 0; c_kill = 0;
    d_valid = 0; d_id = 0; d_rd = 0; d_rdwe = 0; d_rs = 0; d_use = 0;
    w_valid = 0; w_id = 0; w_rd = 0; w_we = 0;
  endtask

  task automatic set_wb(input int j, input int id, input int rd, input bit we);
    w_valid[j] = 1'b1;
    w_id[j*4 +: 4] = 4'(id);
    w_rd[j*5 +: 5] = 5'(rd);
    w_we[j] = we;
  endtask

  task automatic set_disp(input int id, input int rd, input bit we);
    d_valid = 1; d_id = 4'(id); d_rd = 5'(rd); d_rdwe = we;
  endtask

  task automatic set_commit(input int id, input bit kill);
    c_valid = 1; c_id = 4'(id); c_kill = kill;
  endtask

  function automatic int pick_state(int s);
    int base = $urandom_range(0, NI - 1);
    for (int i = 0; i < NI; i++)
      if (m_st[0][(base + i) % NI] == s) return (base + i) % NI;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("disp_ready[%0d]", p), 64'(rdy_w[p]),   64'(e.rdy[p]));
        chk($sformatf("dep_rs[%0d]", p),     64'(deprs_w[p]), 64'(e.deprs[p]));
        chk($sformatf("dep_rd[%0d]", p),     64'(deprd_w[p]), 64'(e.deprd[p]));
        chk($sformatf("fwd[%0d]", p),        64'(fwd_w[p]),   64'(e.fwd[p*6 +: 6]));
        chk($sformatf("pending[%0d]", p),    64'(pend_w[p]),  64'(e.pend[p*32 +: 32]));
        chk($sformatf("busy[%0d]", p),       64'(busy_w[p]),  64'(e.busy[p]));
        chk($sformatf("err[%0d]", p),        64'(err_w[p]),   64'(e.err[p]));
      end
    end
  end

  initial begin
    int k;
    idle();
    rst = 1;
    adv();
    idle(); rst = 1; go(); adv();

    // Basic commit / dispatch / writeback
    idle(); set_commit(3, 0); go(); adv();
    idle(); set_disp(3, 5, 1); go(); chk("basic_ready", 64'(rdy_w[0]), 64'd1); adv();
    idle(); go();
    chk("basic_pend", 64'(pend_w[0][5]), 64'd1);
    chk("basic_busy", 64'(busy_w[0]), 64'd1); adv();
    idle(); set_wb(0, 3, 5, 1); go(); adv();
    idle(); go();
    chk("retire_pend", 64'(pend_w[0][5]), 64'd0);
    chk("retire_busy", 64'(busy_w[0]), 64'd0); adv();

    // Writeback-to-operand bypass
    idle(); set_commit(1, 0); go(); adv();
    idle(); set_disp(1, 5, 1); go(); adv();
    idle(); set_commit(2, 0); go(); adv();
    idle(); set_disp(2, 0, 0); d_use = 3'b001; d_rs = 15'd5; set_wb(1, 1, 5, 1); go();
    chk("fwd_bits", 64'(fwd_w[0]), 64'b000010);
    chk("fwd_deprs", 64'(deprs_w[0]), 64'd0);
    chk("fwd_ready", 64'(rdy_w[0]), 64'd1);
    chk("nofwd_deprs", 64'(deprs_w[1]), 64'd1); adv();
    idle(); set_disp(2, 0, 0); go(); adv();
    idle(); set_wb(0, 2, 0, 0); go(); adv();

    // WAW stall without WAW support, released by a same-cycle writeback
    idle(); set_commit(6, 0); go(); adv();
    idle(); set_disp(6, 7, 1); go(); adv();
    idle(); set_commit(7, 0); go(); adv();
    idle(); set_disp(7, 7, 1); go(); chk("waw_block", 64'(deprd_w[0]), 64'd1); adv();
    idle(); set_disp(7, 7, 1); set_wb(0, 6, 7, 1); go();
    chk("waw_wbpass", 64'(rdy_w[0]), 64'd1); adv();
    idle(); go(); chk("waw_cnt1", 64'(pend_w[0][7]), 64'd1); adv();
    idle(); set_wb(0, 7, 7, 1); go(); adv();

    // WAW counting to saturation with same-cycle commit bypass
    idle(); set_commit(8, 0);  set_disp(8, 2, 1);  go(); adv();
    idle(); set_commit(10, 0); set_disp(10, 2, 1); go(); adv();
    idle(); set_commit(11, 0); set_disp(11, 2, 1); go(); adv();
    idle(); set_commit(12, 0); set_disp(12, 2, 1); go(); chk("sat_block", 64'(deprd_w[1]), 64'd1); adv();
    idle(); set_wb(0, 8, 2, 1); set_wb(1, 10, 2, 1); go(); adv();
    idle(); set_disp(12, 2, 1); go();
    chk("dual_dec_deprd", 64'(deprd_w[1]), 64'd0);
    chk("dual_dec_ready", 64'(rdy_w[1]), 64'd1); adv();
    idle(); rst = 1; go(); adv();

    // ID readiness
    idle(); set_disp(9, 0, 0); go(); chk("id_notcomm", 64'(rdy_w[0]), 64'd0); adv();
    idle(); set_disp(9, 0, 0); set_commit(9, 1); go(); chk("id_kill", 64'(rdy_w[0]), 64'd0); adv();
    idle(); set_disp(9, 0, 0); set_commit(9, 0); go(); chk("id_bypass", 64'(rdy_w[0]), 64'd1); adv();
    idle(); set_wb(0, 9, 0, 0); go(); adv();

    // Sticky error and reset with a writeback in the reset cycle
    idle(); set_wb(0, 4, 0, 0); go(); adv();
    idle(); go(); chk("err_set", 64'(err_w[0]), 64'd1); adv();
    idle(); go(); chk("err_sticky", 64'(err_w[0]), 64'd1); adv();
    idle(); rst = 1; set_commit(1, 0); set_wb(0, 5, 3, 1); go(); adv();
    idle(); go();
    chk("rst_err", 64'(err_w[0]), 64'd0);
    chk("rst_busy", 64'(busy_w[0]), 64'd0);
    chk("rst_pend", 64'(pend_w[0]), 64'd0); adv();

    // Randomised traffic
    for (int c = 0; c < 1500; c++) begin
      idle();
      if (c % 300 == 299) rst = 1;
      if ($urandom_range(0, 99) < 30) begin
        k = pick_state(IDLE);
        if (k < 0 || $urandom_range(0, 9) == 0) k = $urandom_range(0, NI - 1);
        set_commit(k, $urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 99) < 75) begin
        k = pick_state(COMM);
        if (k < 0 || $urandom_range(0, 4) == 0) k = c_valid ? int'(c_id) : $urandom_range(0, NI - 1);
        set_disp(k, $urandom_range(0, 7), $urandom_range(0, 3) != 0);
        d_rs  = 15'($urandom);
        d_rs[4:3] = 2'b00; d_rs[9:8] = 2'b00; d_rs[14:13] = 2'b00;
        d_use = 3'($urandom_range(0, 7));
      end
      for (int j = 0; j < 2; j++) begin
        if ($urandom_range(0, 99) < 35) begin
          k = pick_state(INFL);
          if (k >= 0 && !(j == 1 && w_valid[0] && int'(w_id[3:0]) == k))
            set_wb(j, k, m_rd[0][k], m_we[0][k]);
        end else if ($urandom_range(0, 99) < 3) begin
          set_wb(j, $urandom_range(0, NI - 1), $urandom_range(0, 7), 1'b1);
        end
      end
      go();
      adv();
    end

    idle();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
